// File: rtl/timer_pkg.sv
// Shared encodings for the timer/counter group.
package timer_pkg;

    localparam int DEF_WIDTH = 8;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/down_counter_reload.sv
// Programmable down counter with reload register, one-shot/periodic modes and underflow pulse.
// Latency: every control input takes effect at the next clk edge; all outputs registered or state-decoded.
// Backpressure: none; EN is a free-running tick qualifier and is simply ignored outside RUN.
module down_counter_reload
    import timer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VAL,
    input  logic             START,
    input  logic             STOP,
    input  logic             EN,
    input  logic             CLR,
    input  logic             MODE,
    output logic [WIDTH-1:0] counter,
    output logic             UF,
    output logic             BUSY,
    output logic             DONE
);

    state_t           state;
    logic [WIDTH-1:0] reload_reg;

    // One strict priority chain: the first asserted control owns the cycle.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            counter    <= '0;
            reload_reg <= '0;
            UF         <= 1'b0;
            state      <= S_IDLE;
        end else begin
            UF <= 1'b0;
            if (CLR) begin
                counter <= '0;
                state   <= S_IDLE;
            end else if (LOAD) begin
                reload_reg <= LOAD_VAL;
                counter    <= LOAD_VAL;
                if (state == S_DONE)
                    state <= S_IDLE;
            end else if (STOP) begin
                if (state == S_RUN)
                    state <= S_IDLE;
            end else if (START) begin
                if (state == S_IDLE) begin
                    state <= S_RUN;
                end else if (state == S_DONE) begin
                    counter <= reload_reg;
                    state   <= S_RUN;
                end
            end else if (EN && state == S_RUN) begin
                if (counter != '0) begin
                    counter <= counter - 1'b1;
                end else begin
                    // Underflow never wraps: reload in periodic mode, park at zero otherwise.
                    UF <= 1'b1;
                    if (MODE == MODE_PERIODIC)
                        counter <= reload_reg;
                    else
                        state <= S_DONE;
                end
            end
        end
    end

    assign BUSY = (state == S_RUN);
    assign DONE = (state == S_DONE);

endmodule

// File: doc/down_counter_reload.md
Name: down_counter_reload

Overview:
Programmable down-counting timer with reload and an underflow flag. It is the counting-down counterpart of the team's 8-bit up counter with overflow flag.
Loads a start value, decrements on each enabled clock, and flags underflow. In periodic mode it auto-reloads; in one-shot mode it stops in DONE.
Sits next to the up counter in the timer/counter group and produces the tick/timeout pulses that the up counter counts.

Parameters:
WIDTH, 8, counter and reload register width in bits

Ports:
clk  input  1  system clock @ 10 MHz
Reset  input  1  synchronous, active-low reset
LOAD  input  1  capture LOAD_VAL into reload register and counter
LOAD_VAL  input  WIDTH  start/reload value
START  input  1  begin or resume counting
STOP  input  1  pause counting; counter value is held
EN  input  1  decrement qualifier (tick)
CLR  input  1  clear counter, abort to IDLE
MODE  input  1  0 = one-shot, 1 = periodic auto-reload
counter  output  WIDTH  current count (registered)
UF  output  1  underflow pulse, one cycle wide (registered)
BUSY  output  1  high while state is RUN
DONE  output  1  high while state is DONE (one-shot complete)

Behaviour:
- Reset: reset is Reset, synchronous, active-low; clock is clk. When Reset is low at a clk rising edge:
  - counter = 0, reload_reg = 0, UF = 0, state = IDLE; so BUSY = 0 and DONE = 0.
- Per-cycle priority: Reset > CLR > LOAD > STOP > START > EN.
- UF default: UF is 0 every cycle unless set by an underflow event below.
- States: IDLE, RUN, DONE.
- CLR (any state): counter = 0, state = IDLE. reload_reg is kept.
- LOAD (any state):
  - reload_reg = LOAD_VAL, counter = LOAD_VAL.
  - DONE -> IDLE; IDLE and RUN keep their state. A LOAD during RUN restarts the count from the new value.
- STOP: RUN -> IDLE, counter held. STOP in IDLE or DONE is ignored. STOP together with START: STOP wins.
- START:
  - IDLE -> RUN, counter unchanged.
  - DONE -> RUN with counter = reload_reg.
  - START in RUN is ignored.
- EN is honoured only in RUN. An EN in the same cycle as the START that enters RUN is not counted; the first decrement happens on the following cycle.
- RUN, EN = 1, counter != 0: counter = counter - 1.
- RUN, EN = 1, counter == 0 (underflow event): UF = 1 on the next cycle.
  - MODE = 1: counter = reload_reg, stay in RUN.
  - MODE = 0: counter stays 0, state = DONE.
- Wrap rules:
  - counter never wraps to all-ones. Underflow always yields reload_reg (periodic) or 0 (one-shot).
  - WIDTH-bit unsigned arithmetic throughout.
- reload_reg = 0:
  - Periodic mode: UF fires on every EN cycle in RUN.
  - One-shot mode: the first EN gives UF and DONE.
- Period: with reload value N in periodic mode, UF fires every N+1 EN ticks.
- MODE is sampled at the underflow cycle only. Changing MODE mid-count is legal.
- Reset mid-count: next cycle all outputs are at reset values, with no UF pulse.
- Outputs: all are registered or decoded directly from the state register; no input-to-output combinational paths.

Decomposition:
- Shared package (timer_pkg):
  - state encoding constants ST_IDLE = 2'b00, ST_RUN = 2'b01, ST_DONE = 2'b10;
  - MODE_ONESHOT = 1'b0, MODE_PERIODIC = 1'b1;
  - default WIDTH.
- No sub-module is needed; the state register, reload register and counter datapath stay in one module.
- Optional reuse: the existing up counter can be chained on UF to count periods.

Test Plan:
- Reset low for 2 cycles while START = 1, EN = 1 -> counter = 0, UF = 0, BUSY = 0, DONE = 0; after release, state is still IDLE until a new START.
- LOAD_VAL = 3, LOAD, then START, EN held high, MODE = 0 -> counter 3, 2, 1, 0; UF = 1 for exactly one cycle; DONE = 1; counter stays 0 with further EN.
- LOAD_VAL = 2, MODE = 1, START, EN high for 9 cycles -> counter sequence 2, 1, 0, 2, 1, 0, 2, 1, 0; UF pulses once every 3 EN cycles; BUSY stays 1.
- LOAD 8'h05, START, 2 ENs (counter = 3), STOP with 3 more EN cycles -> counter held at 3, BUSY = 0; then START resumes -> next EN gives 2.
- Simultaneous events:
  - CLR with LOAD = 1 and EN = 1 in RUN -> counter = 0, state IDLE, no UF.
  - LOAD_VAL = 8'hFF with EN in RUN -> counter = 8'hFF, state stays RUN.
- LOAD_VAL = 0, MODE = 1, START, EN toggling 1/0 -> UF = 1 on the cycle after each EN; counter stays 0.
